// File: rtl/handshake_arbiter.sv
// Round-robin arbiter that shares one four-phase strobe/ack channel among N_REQ requesters.
// A grant latches the winner's payload; each transaction ends in one done or one timeout err pulse.
module handshake_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10,
    localparam int OWN_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data_i,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic                    stb,
    output logic [DATA_W-1:0]       data_o,
    output logic [OWN_W-1:0]        owner,
    input  logic                    ack,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? {TO_W{1'b0}} : TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

    state_t              state_r;
    state_t              state_s;
    logic [OWN_W-1:0]    ptr_r;
    logic [OWN_W-1:0]    ptr_s;
    logic [TO_W-1:0]     cnt_r;
    logic [TO_W-1:0]     cnt_s;
    logic [N_REQ-1:0]    elig_s;
    logic                found_s;
    logic [OWN_W-1:0]    win_s;
    logic [OWN_W-1:0]    cand_s;
    logic [DATA_W-1:0]   pay_s;
    logic                stb_s;
    logic [DATA_W-1:0]   data_s;
    logic [OWN_W-1:0]    owner_s;
    logic [N_REQ-1:0]    done_s;
    logic [N_REQ-1:0]    err_s;
    logic                busy_s;

    function automatic logic [OWN_W-1:0] next_idx(input logic [OWN_W-1:0] idx);
        logic [OWN_W-1:0] nxt;
        if (idx == OWN_W'(N_REQ - 1)) begin
            nxt = OWN_W'(0);
        end else begin
            nxt = idx + OWN_W'(1);
        end
        return nxt;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [OWN_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec = {N_REQ{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            if (idx == OWN_W'(k)) begin
                vec[k] = 1'b1;
            end else begin
                vec[k] = 1'b0;
            end
        end
        return vec;
    endfunction

    // Round-robin winner search starting at the pointer; the completing requester is masked.
    always_comb begin
        elig_s  = req & ~(done | err);
        found_s = 1'b0;
        win_s   = ptr_r;
        cand_s  = ptr_r;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_s && elig_s[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
            cand_s = next_idx(cand_s);
        end
    end

    // Payload multiplexer selecting the winner's slice of data_i.
    always_comb begin
        pay_s = {DATA_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            if (win_s == OWN_W'(k)) begin
                pay_s = data_i[k*DATA_W +: DATA_W];
            end else begin
                pay_s = pay_s;
            end
        end
    end

    // Four-phase sequencing: next state and next values of every registered output.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        stb_s   = stb;
        data_s  = data_o;
        owner_s = owner;
        done_s  = {N_REQ{1'b0}};
        err_s   = {N_REQ{1'b0}};
        case (state_r)
            IDLE: begin
                // A stale acknowledge still high blocks any new grant.
                if (found_s && !ack) begin
                    state_s = REQ;
                    stb_s   = 1'b1;
                    owner_s = win_s;
                    data_s  = pay_s;
                    cnt_s   = {TO_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (ack) begin
                    state_s = RELEASE;
                    stb_s   = 1'b0;
                end else if ((TIMEOUT != 0) && (cnt_r == TO_LAST)) begin
                    state_s = DRAIN;
                    stb_s   = 1'b0;
                    err_s   = onehot(owner);
                end else if (cnt_r != TO_MAX) begin
                    cnt_s = cnt_r + TO_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            RELEASE: begin
                if (!ack) begin
                    state_s = IDLE;
                    done_s  = onehot(owner);
                    ptr_s   = next_idx(owner);
                end else begin
                    state_s = RELEASE;
                end
            end
            DRAIN: begin
                if (!ack) begin
                    state_s = IDLE;
                    ptr_s   = next_idx(owner);
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
                stb_s   = 1'b0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            ptr_r   <= OWN_W'(0);
            cnt_r   <= {TO_W{1'b0}};
            stb     <= 1'b0;
            data_o  <= {DATA_W{1'b0}};
            owner   <= OWN_W'(0);
            done    <= {N_REQ{1'b0}};
            err     <= {N_REQ{1'b0}};
            busy    <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            stb     <= stb_s;
            data_o  <= data_s;
            owner   <= owner_s;
            done    <= done_s;
            err     <= err_s;
            busy    <= busy_s;
        end
    end

endmodule

// File: tb/tb_handshake_arbiter.sv
// Scoreboard bench for handshake_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares them whenever stb rises or done/err pulses.
module tb_handshake_arbiter;

    localparam logic [31:0] D0  = 32'hAAAA_0000;
    localparam logic [31:0] D1  = 32'h1234_5678;
    localparam logic [31:0] D2  = 32'hCCCC_0002;
    localparam logic [31:0] D3  = 32'hDDDD_0003;
    localparam logic [31:0] D3B = 32'hBAD0_0033;

    logic         clk;
    logic         rstn;
    logic         ack;
    logic [3:0]   req;
    logic [127:0] data_i;
    logic [3:0]   done;
    logic [3:0]   err;
    logic         stb;
    logic [31:0]  data_o;
    logic [1:0]   owner;
    logic         busy;

    handshake_arbiter #(
        .N_REQ(4), .DATA_W(32), .TIMEOUT(8), .TO_W(10)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .data_i(data_i), .done(done), .err(err),
        .stb(stb), .data_o(data_o), .owner(owner), .ack(ack), .busy(busy)
    );

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] data;
    } grant_t;

    typedef struct {
        logic [3:0] done;
        logic [3:0] err;
        int         lat;
    } resp_t;

    grant_t gq[$];
    resp_t  rq[$];
    int     n_cmp;
    int     n_fail;
    int     up_cnt;
    int     dn_cnt;
    int     ack_up;
    int     ack_dn;
    logic   ack_auto;
    logic   auto_drop;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_grant(input logic [1:0] idx, input logic [31:0] d);
        grant_t g;
        g.idx  = idx;
        g.data = d;
        gq.push_back(g);
    endtask

    task automatic exp_txn(input logic [1:0] idx, input logic [31:0] d, input logic is_err, input int lat);
        resp_t r;
        exp_grant(idx, d);
        r.done = is_err ? 4'b0000 : (4'b0001 << idx);
        r.err  = is_err ? (4'b0001 << idx) : 4'b0000;
        r.lat  = lat;
        rq.push_back(r);
    endtask

    // One cycle: drive after the edge, emulate requesters dropping req and the ack responder.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) req = req & ~(done | err);
        if (ack_auto) begin
            if (stb && !ack) begin
                up_cnt++;
                if (up_cnt >= ack_up) begin
                    ack    = 1'b1;
                    up_cnt = 0;
                end
            end else if (!stb && ack) begin
                dn_cnt++;
                if (dn_cnt >= ack_dn) begin
                    ack    = 1'b0;
                    dn_cnt = 0;
                end
            end else begin
                up_cnt = 0;
                dn_cnt = 0;
            end
        end
    endtask

    task automatic wait_idle(input string name, input int max);
        int k;
        k = 0;
        tick();
        while (!(busy == 1'b0 && req == 4'b0000) && k < max) begin
            tick();
            k++;
        end
        if (k >= max) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no return to idle within %0d cycles", name, max);
        end
        repeat (2) tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stb"},   32'(stb),   32'd0);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_err"},   32'(err),   32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'd0);
    endtask

    // Monitor: pops the grant queue on each stb rise, the response queue on each done/err pulse.
    initial begin
        logic        stb_q;
        logic [31:0] data_q;
        int          cyc;
        int          gcyc;
        grant_t      g;
        resp_t       r;
        stb_q  = 1'b0;
        data_q = 32'd0;
        cyc    = 0;
        gcyc   = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                stb_q = 1'b0;
            end else begin
                if (stb && !stb_q) begin
                    gcyc = cyc;
                    if (gq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_grant: owner %0d, none expected", owner);
                    end else begin
                        g = gq.pop_front();
                        chk("grant_owner", 32'(owner), 32'(g.idx));
                        chk("grant_data", data_o, g.data);
                    end
                end
                if (stb && stb_q) chk("data_stable", data_o, data_q);
                if ((done | err) != 4'b0000) begin
                    chk("done_err_onehot", 32'($countones(done | err)), 32'd1);
                    if (rq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_resp: done %b err %b, none expected", done, err);
                    end else begin
                        r = rq.pop_front();
                        chk("resp_done", 32'(done), 32'(r.done));
                        chk("resp_err", 32'(err), 32'(r.err));
                        chk("resp_latency", 32'(cyc - gcyc), 32'(r.lat));
                    end
                end
                stb_q  = stb;
                data_q = data_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_done;
        int hi;
        int k;
        n_cmp     = 0;
        n_fail    = 0;
        up_cnt    = 0;
        dn_cnt    = 0;
        ack_up    = 1;
        ack_dn    = 1;
        ack_auto  = 1'b0;
        auto_drop = 1'b0;
        rstn      = 1'b0;
        ack       = 1'b0;
        req       = 4'b0000;
        data_i    = {D3, D2, D1, D0};

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_data_o", data_o, 32'd0);
        rstn = 1'b1;
        tick();

        // All four request together: strict order 0,1,2,3 with minimum 1-cycle ack phases.
        ack_auto  = 1'b1;
        auto_drop = 1'b1;
        exp_txn(2'd0, D0, 1'b0, 2);
        exp_txn(2'd1, D1, 1'b0, 2);
        exp_txn(2'd2, D2, 1'b0, 2);
        exp_txn(2'd3, D3, 1'b0, 2);
        req = 4'b1111;
        wait_idle("rr_all4", 60);

        // Requesters 0 and 3 held continuously alternate.
        auto_drop = 1'b0;
        exp_txn(2'd0, D0, 1'b0, 2);
        exp_txn(2'd3, D3, 1'b0, 2);
        exp_txn(2'd0, D0, 1'b0, 2);
        exp_txn(2'd3, D3, 1'b0, 2);
        req    = 4'b1001;
        n_done = 0;
        k      = 0;
        while (!(n_done == 4 && busy == 1'b0) && k < 80) begin
            tick();
            if (done != 4'b0000) n_done++;
            if (n_done == 4) req = 4'b0000;
            k++;
        end
        chk("alt_done_count", 32'(n_done), 32'd4);
        repeat (2) tick();

        // Single request with slow ack (3 cycles up, 2 down).
        auto_drop = 1'b1;
        ack_up    = 3;
        ack_dn    = 2;
        exp_txn(2'd1, D1, 1'b0, 5);
        req = 4'b0010;
        tick();
        chk("grant_latency_stb", 32'(stb), 32'd1);
        chk("grant_latency_busy", 32'(busy), 32'd1);
        wait_idle("single", 40);

        // Request withdrawn after grant; payload changed after grant must not reach data_o.
        ack_up = 2;
        ack_dn = 2;
        exp_txn(2'd3, D3, 1'b0, 4);
        req = 4'b1000;
        tick();
        req            = 4'b0000;
        data_i[127:96] = D3B;
        wait_idle("withdraw", 40);
        data_i[127:96] = D3;

        // Timeout: ack never answers, stb high exactly 8 cycles then err[2].
        ack_auto = 1'b0;
        ack      = 1'b0;
        exp_txn(2'd2, D2, 1'b1, 8);
        req = 4'b0100;
        hi  = 0;
        k   = 0;
        tick();
        while ((busy || req != 4'b0000) && k < 40) begin
            if (stb) hi++;
            tick();
            k++;
        end
        chk("timeout_bounded", 32'(k < 40), 32'd1);
        chk("timeout_stb_cycles", 32'(hi), 32'd8);
        repeat (2) tick();

        // Late/stuck ack: no grant while ack=1, grant right after ack is sampled low.
        ack = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_grant_ack_high", 32'(stb), 32'd0);
        end
        exp_txn(2'd0, D0, 1'b0, 2);
        ack      = 1'b0;
        ack_up   = 1;
        ack_dn   = 1;
        ack_auto = 1'b1;
        tick();
        chk("grant_after_ack_low", 32'(stb), 32'd1);
        wait_idle("late_ack", 40);

        // Asynchronous reset while in REQ.
        ack_auto  = 1'b0;
        auto_drop = 1'b0;
        ack       = 1'b0;
        exp_grant(2'd2, D2);
        req = 4'b0100;
        tick();
        chk("rst_req_stb_up", 32'(stb), 32'd1);
        tick();
        #1 rstn = 1'b0;
        #1;
        chk_reset_outputs("rst_in_req");
        req = 4'b0000;
        #1 rstn = 1'b1;
        repeat (2) tick();

        // Asynchronous reset while in RELEASE; pointer restarted so 0 wins over 3.
        exp_grant(2'd0, D0);
        req = 4'b1001;
        tick();
        chk("rst_rel_stb_up", 32'(stb), 32'd1);
        ack = 1'b1;
        tick();
        chk("rst_rel_stb_low", 32'(stb), 32'd0);
        chk("rst_rel_busy", 32'(busy), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk_reset_outputs("rst_in_release");
        req = 4'b0000;
        ack = 1'b0;
        #1 rstn = 1'b1;
        repeat (2) tick();

        // After reset the pointer is 0 again: 0 first, then 3.
        ack_auto  = 1'b1;
        auto_drop = 1'b1;
        exp_txn(2'd0, D0, 1'b0, 2);
        exp_txn(2'd3, D3, 1'b0, 2);
        req = 4'b1001;
        wait_idle("post_reset", 40);

        chk("grant_queue_empty", 32'(gq.size()), 32'd0);
        chk("resp_queue_empty", 32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
